// File: rtl/lsu_ctrl.sv
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : RV32I load/store controller for a word-wide data memory without
//             byte enables (sub-word stores use read-modify-write).
//             Optional macro LSU_MISALIGN_TRAP_EN enables the misalignment
//             FAULT path; otherwise misaligned addresses are force-aligned.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl #(
    parameter int WORD_ADDR_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rd_valid,
    output logic [31:0] o_rd_data,
    output logic        o_done,
    output logic        o_misaligned
);

    // Keeps the word-index bits only; the 33-bit intermediate lets
    // WORD_ADDR_W reach 30 without the shift overflowing.
    localparam logic [32:0] c_ADDR_LIM  = 33'd1 << (WORD_ADDR_W + 2);
    localparam logic [31:0] c_ADDR_MASK = (c_ADDR_LIM[31:0] - 32'd1) & 32'hFFFF_FFFC;

    localparam logic [1:0] c_SZ_B = 2'd0;
    localparam logic [1:0] c_SZ_H = 2'd1;
    localparam logic [1:0] c_SZ_W = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        S_FAULT  = 3'd4
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        w_accept;
    logic        w_fault;
    logic [1:0]  w_size;
    logic [1:0]  w_lane;

    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_done;

    logic [4:0]  w_shift;
    logic [31:0] w_lane_word;
    logic [31:0] w_load_data;
    logic [31:0] w_mask;
    logic [31:0] w_ins;
    logic [31:0] w_merged;

    // ------------------------------------------------------------------
    // Request decode (funct3 values 011/110/111 collapse onto word size)
    // ------------------------------------------------------------------
    assign w_accept = i_valid & (r_state == S_IDLE) & (i_load | i_store);
    assign w_size   = i_funct3[1] ? c_SZ_W : (i_funct3[0] ? c_SZ_H : c_SZ_B);
    assign w_lane   = (w_size == c_SZ_W) ? 2'b00 :
                      (w_size == c_SZ_H) ? {i_addr[1], 1'b0} : i_addr[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misal;
    logic r_misal;
    assign w_misal      = ((w_size == c_SZ_H) & i_addr[0]) |
                          ((w_size == c_SZ_W) & (|i_addr[1:0]));
    assign w_fault      = w_misal;
    assign o_misaligned = r_misal;
`else
    assign w_fault      = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        o_ready  = 1'b0;
        o_mem_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (w_accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (w_fault)
                        w_next = S_FAULT;
                    else
`endif
                    if (i_load)
                        w_next = S_LOAD;
                    else if (w_size == c_SZ_W)
                        w_next = S_WRITE;
                    else
                        w_next = S_RMW_RD;
                end
            end
            S_LOAD:   w_next = S_IDLE;
            S_RMW_RD: w_next = S_WRITE;
            S_WRITE: begin
                o_mem_we = 1'b1;
                w_next   = S_IDLE;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            S_FAULT:  w_next = S_IDLE;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane extraction and merge; a half lane always has lane[0] = 0, so
    // one byte-granular shift serves both widths.
    // ------------------------------------------------------------------
    assign w_shift     = {r_lane, 3'b000};
    assign w_lane_word = i_mem_rdata >> w_shift;

    always_comb begin
        w_load_data = i_mem_rdata;
        case (r_size)
            c_SZ_B:  w_load_data = {{24{~r_unsigned & w_lane_word[7]}},  w_lane_word[7:0]};
            c_SZ_H:  w_load_data = {{16{~r_unsigned & w_lane_word[15]}}, w_lane_word[15:0]};
            default: w_load_data = i_mem_rdata;
        endcase
    end

    assign w_mask   = ((r_size == c_SZ_H) ? 32'h0000_FFFF : 32'h0000_00FF) << w_shift;
    assign w_ins    = {16'h0000, r_wdata} << w_shift;
    assign w_merged = (i_mem_rdata & ~w_mask) | (w_ins & w_mask);

    // ------------------------------------------------------------------
    // Datapath registers and completion pulses
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lane      <= 2'b00;
            r_size      <= c_SZ_B;
            r_unsigned  <= 1'b0;
            r_wdata     <= 16'h0000;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_rd_data   <= 32'h0000_0000;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_valid <= (r_state == S_LOAD);
            r_done     <= (r_state == S_WRITE);
            if (w_accept) begin
                r_lane     <= w_lane;
                r_size     <= w_size;
                r_unsigned <= i_funct3[2];
                r_wdata    <= i_wdata[15:0];
                // A faulting request leaves the memory-side registers untouched
                if (!w_fault) begin
                    r_mem_addr <= i_addr & c_ADDR_MASK;
                    if (!i_load && (w_size == c_SZ_W))
                        r_mem_wdata <= i_wdata;
                end
            end
            if (r_state == S_LOAD)
                r_rd_data <= w_load_data;
            if (r_state == S_RMW_RD)
                r_mem_wdata <= w_merged;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_misal <= 1'b0;
        end else begin
            r_misal <= (r_state == S_FAULT);
        end
    end
`endif

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Purpose  : Randomised self-checking bench for lsu_ctrl against a byte-array
//             memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic        o_done;
    logic        o_misaligned;

    lsu_ctrl #(.WORD_ADDR_W(8)) u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_load       (i_load),
        .i_store      (i_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .o_done       (o_done),
        .o_misaligned (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    // Word memory seen by the DUT, and the reference view as plain bytes
    logic [31:0] mem [256];
    logic [7:0]  ref_mem [1024];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_val = 32'd0;

    assign i_mem_rdata = mem[o_mem_addr[9:2]];

    always @(posedge i_clk) begin
        if (o_mem_we)
            mem[o_mem_addr[9:2]] <= o_mem_wdata;
        else if (pre_we)
            mem[pre_idx] <= pre_val;
    end

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_rd = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int widx);
        return {ref_mem[widx*4+3], ref_mem[widx*4+2], ref_mem[widx*4+1], ref_mem[widx*4]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int ea, input int size);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < size; i++)
            v = v | (32'(ref_mem[ea+i]) << (8*i));
        if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Starts and ends at a falling edge
    task automatic set_word(input int widx, input logic [31:0] val);
        pre_idx = widx[7:0];
        pre_val = val;
        pre_we  = 1'b1;
        @(negedge i_clk);
        pre_we  = 1'b0;
        for (int i = 0; i < 4; i++)
            ref_mem[widx*4+i] = val[8*i +: 8];
    endtask

    // One request; returns at the falling edge of its completion-pulse cycle
    task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
        bit          isld = ld;
        bit          isst = !ld && st;
        int          size = f3[1] ? 4 : (f3[0] ? 2 : 1);
        bit          mis = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
        bit          flt;
        int          ea;
        int          exp_lat, exp_we, lat, we_cnt;
        logic [2:0]  exp_pulse, pulse;
        logic [31:0] exp_rd = 32'd0;
        logic [31:0] prev_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        flt = mis;
`else
        flt = 1'b0;
`endif
        ea = int'(addr & 32'h0000_03FF);
        if (size == 2) ea = ea & ~1;
        if (size == 4) ea = ea & ~3;

        i_valid  = 1'b1;
        i_load   = ld;
        i_store  = st;
        i_funct3 = f3;
        i_addr   = addr;
        i_wdata  = wd;

        if (!isld && !isst) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            check_eq("noop_ready", 32'(o_ready), 32'd1);
            check_eq("noop_quiet", {28'd0, o_mem_we, o_rd_valid, o_done, o_misaligned}, 32'd0);
            rd = o_rd_data;
            return;
        end

        prev_addr = o_mem_addr;
        if (isld && !flt) exp_rd = ref_load(f3, ea, size);
        exp_lat   = (!flt && isst && size < 4) ? 3 : 2;
        exp_pulse = flt ? 3'b001 : (isld ? 3'b100 : 3'b010);
        exp_we    = (!flt && isst) ? 1 : 0;
        check_eq("ready_idle", 32'(o_ready), 32'd1);

        @(posedge i_clk);
        #1;
        // Junk on the request port while busy must be ignored
        i_load   = 1'($urandom);
        i_store  = 1'($urandom);
        i_funct3 = 3'($urandom);
        i_addr   = $urandom;
        i_wdata  = $urandom;

        lat = 0; we_cnt = 0; pulse = 3'b000;
        for (int k = 1; k <= 5 && lat == 0; k++) begin
            @(negedge i_clk);
            if (k == 1) begin
                check_eq("busy_ready", 32'(o_ready), 32'd0);
                check_eq("mem_addr", o_mem_addr, flt ? prev_addr : (32'(ea) & 32'hFFFF_FFFC));
            end
            if (o_mem_we) we_cnt++;
            pulse = {o_rd_valid, o_done, o_misaligned};
            if (pulse != 3'b000) lat = k;
        end
        i_valid = 1'b0;

        check_eq("latency",     32'(lat),    32'(exp_lat));
        check_eq("pulse",       32'(pulse),  32'(exp_pulse));
        check_eq("we_cycles",   32'(we_cnt), 32'(exp_we));
        check_eq("ready_after", 32'(o_ready), 32'd1);
        if (isld && !flt) last_rd = exp_rd;
        check_eq("rd_data", o_rd_data, last_rd);
        if (isst && !flt) begin
            for (int i = 0; i < size; i++)
                ref_mem[ea+i] = wd[8*i +: 8];
            check_eq("mem_word", mem[ea/4], ref_word(ea/4));
        end
        rd = o_rd_data;
    endtask

    initial begin
        logic [31:0] rd;
        int          op;
        logic [31:0] a;

        i_rst = 1'b1; i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
        i_funct3 = 3'd0; i_addr = 32'd0; i_wdata = 32'd0;
        repeat (3) @(negedge i_clk);
        check_eq("rst_ready", 32'(o_ready), 32'd1);
        check_eq("rst_pulses", {28'd0, o_mem_we, o_rd_valid, o_done, o_misaligned}, 32'd0);
        check_eq("rst_rd_data", o_rd_data, 32'd0);
        check_eq("rst_mem_addr", o_mem_addr, 32'd0);
        check_eq("rst_mem_wdata", o_mem_wdata, 32'd0);
        i_rst = 1'b0;

        for (int w = 0; w < 256; w++)
            set_word(w, $urandom);

        // Lane extraction and extension
        set_word(3, 32'h80FF_7F01);
        do_req(1'b1, 1'b0, 3'b000, 32'h0000_000D, 32'd0, rd);
        check_eq("tp_lb_0d", rd, 32'h0000_007F);
        do_req(1'b1, 1'b0, 3'b000, 32'h0000_000F, 32'd0, rd);
        check_eq("tp_lb_0f", rd, 32'hFFFF_FF80);
        do_req(1'b1, 1'b0, 3'b100, 32'h0000_000F, 32'd0, rd);
        check_eq("tp_lbu_0f", rd, 32'h0000_0080);

        // Sub-word read-modify-write
        set_word(3, 32'h1122_3344);
        do_req(1'b0, 1'b1, 3'b001, 32'h0000_000E, 32'h0000_ABCD, rd);
        check_eq("tp_sh_word", mem[3], 32'hABCD_3344);
        set_word(3, 32'h1122_3344);
        do_req(1'b0, 1'b1, 3'b000, 32'h0000_000C, 32'h0000_005A, rd);
        do_req(1'b1, 1'b0, 3'b010, 32'h0000_000C, 32'd0, rd);
        check_eq("tp_sb_lw", rd, 32'h1122_335A);

        // Full-word store, then the misaligned word load
        do_req(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, rd);
        check_eq("tp_sw_word", mem[8], 32'hDEAD_BEEF);
        set_word(1, 32'hCAFE_0123);
        do_req(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
        check_eq("tp_lw_06_aligned", rd, 32'hCAFE_0123);
`endif

        // Neither load nor store
        do_req(1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'd0, rd);

        // Reset while an SB sits in its read phase
        set_word(3, 32'h1122_3344);
        i_valid = 1'b1; i_load = 1'b0; i_store = 1'b1; i_funct3 = 3'b000;
        i_addr = 32'h0000_000C; i_wdata = 32'h0000_005A;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_eq("rst_mid_ready", 32'(o_ready), 32'd1);
        check_eq("rst_mid_pulses", {28'd0, o_mem_we, o_rd_valid, o_done, o_misaligned}, 32'd0);
        i_rst = 1'b0;
        last_rd = 32'd0;
        @(negedge i_clk);
        check_eq("rst_mid_we", 32'(o_mem_we), 32'd0);
        check_eq("rst_mid_mem", mem[3], 32'h1122_3344);

        // Randomised traffic, back-to-back
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
            if (op == 0)
                do_req(1'b0, 1'b0, 3'($urandom), a, $urandom, rd);
            else if (op <= 3)
                do_req(1'b1, 1'($urandom), 3'($urandom), a, $urandom, rd);
            else
                do_req(1'b0, 1'b1, 3'($urandom), a, $urandom, rd);
        end

        for (int w = 0; w < 256; w++)
            check_eq("final_mem", mem[w], ref_word(w));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the execute stage and the word-wide `data_memory` port in the MEM stage. It turns RV32I `LB/LH/LW/LBU/LHU/SB/SH/SW` requests into word accesses:
- Loads are performed directly, with lane extraction and sign/zero extension.
- Sub-word stores use a two-step read-modify-write, because the memory has no byte enables.

A ready/valid handshake stalls the pipeline while an access is in flight.

## Interface
Parameters:
- `WORD_ADDR_W`, default 8: word-index width of data memory. Address bits above `WORD_ADDR_W+1` are forced to 0 on `o_mem_addr`.

Ports:
- `i_clk` in 1: the block's one clock.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_valid` in 1: request valid from EX.
- `o_ready` out 1: controller can accept a request.
- `i_load` in 1: request is a load.
- `i_store` in 1: request is a store. If both `i_load` and `i_store` are 1, the request is treated as a load.
- `i_funct3` in 3: RV32I width/sign code. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `i_addr` in 32: byte address.
- `i_wdata` in 32: store data, right-aligned.
- `o_mem_we` out 1: data memory write enable.
- `o_mem_addr` out 32: word-aligned address. Bits [1:0] are always 00.
- `o_mem_wdata` out 32: full word to write.
- `i_mem_rdata` in 32: combinational read data for `o_mem_addr`.
- `o_rd_valid` out 1: load result valid. One-cycle pulse.
- `o_rd_data` out 32: extended load result.
- `o_done` out 1: store committed. One-cycle pulse.
- `o_misaligned` out 1: misaligned access dropped. One-cycle pulse.

## Operation
- States are IDLE, LOAD, RMW_RD, WRITE and FAULT.
- A request is accepted on a rising edge where `i_valid & o_ready` is 1. On acceptance the block captures `addr`, `funct3`, `wdata` and the load/store type. A `funct3` value of 011, 110 or 111 is treated as W.
- `o_ready` is 1 only in IDLE.
- Transitions out of IDLE on acceptance:
  - A misaligned request goes to FAULT. Misaligned means H/HU with `addr[0]` = 1, or W with `addr[1:0]` ≠ 0.
  - A load goes to LOAD.
  - SW goes to WRITE, with captured word = `wdata`.
  - SB/SH goes to RMW_RD.
  - If `i_valid` is 0, or both `i_load` and `i_store` are 0, the block stays in IDLE.
- LOAD:
  - Drives `o_mem_addr`.
  - Selects lane `addr[1:0]`: byte lane = `rdata[8*a+7:8*a]`, half lane = `rdata[16*a[1]+15:16*a[1]]`.
  - B/H are sign-extended; BU/HU are zero-extended.
  - Registers the result into `o_rd_data` and sets `o_rd_valid` for the next cycle, then goes to IDLE.
- RMW_RD:
  - Drives `o_mem_addr`.
  - Merges `wdata[7:0]` (SB) or `wdata[15:0]` (SH) into `i_mem_rdata` at the addressed lane. All other lanes are kept.
  - Stores the merged word, then goes to WRITE.
- WRITE:
  - Drives `o_mem_we` = 1, `o_mem_addr` and `o_mem_wdata` = captured word. The memory commits on the edge that ends this cycle.
  - Sets `o_done` for the next cycle, then goes to IDLE.
- FAULT: sets `o_misaligned` for the next cycle, then goes to IDLE. No memory access is made.
- Pulses are registered and overlap the first IDLE cycle after the operation, so a new request can be accepted in that cycle.
- `o_rd_data` holds its last value until the next load completes.
- `o_mem_we` is 0 in every state except WRITE.
- In IDLE and FAULT, `o_mem_wdata` and `o_mem_addr` hold their last value.

## Timing
- Reset values:
  - State = IDLE.
  - `o_ready` = 1.
  - `o_mem_we`, `o_rd_valid`, `o_done`, `o_misaligned` = 0.
  - `o_rd_data`, `o_mem_addr`, `o_mem_wdata` = 0.
- Latencies, with acceptance at edge N:
  - Load: `o_rd_valid` high in cycle N+2, which is 2 cycles of occupancy.
  - SW: write commits at edge N+2; `o_done` high in cycle N+2.
  - SB/SH: RMW_RD in N+1, WRITE in N+2; commit at edge N+3; `o_done` high in cycle N+3.
  - Fault: `o_misaligned` high in cycle N+2.
- Back-to-back operation: a request accepted in the pulse cycle starts its own sequence. Throughput is one load per 2 cycles.
- Reset asserted mid-operation: the FSM returns to IDLE at that edge. A pending write is abandoned; `o_mem_we` is 0 in the cycle after reset.
- Request inputs are ignored while `o_ready` = 0.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misalignment is detected and goes to FAULT as described above.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - There is no FAULT state and `o_misaligned` is tied to 0.
  - A misaligned address is forced to natural alignment (H: `addr[0]` cleared; W: `addr[1:0]` cleared) and the access proceeds normally.

## Test plan
- Memory word 3 = 0x80FF_7F01. `LB` at 0x0D gives `o_rd_data` = 0x0000_007F; `LB` at 0x0F gives 0xFFFF_FF80; `LBU` at 0x0F gives 0x0000_0080; each `o_rd_valid` arrives 2 cycles after accept.
- Memory word 3 = 0x1122_3344. `SH` 0xABCD at 0x0E gives word 3 = 0xABCD_3344; `o_done` at N+3, with exactly one `o_mem_we` cycle.
- `SB` 0x5A at 0x0C on 0x1122_3344 gives word 3 = 0x1122_335A; a following `LW` at 0x0C returns 0x1122_335A.
- `SW` 0xDEAD_BEEF at 0x20 gives word 8 = 0xDEAD_BEEF; `o_done` at N+2; `o_ready` is low only in N+1.
- With `LSU_MISALIGN_TRAP_EN`: `LW` at 0x06 gives `o_misaligned` at N+2, no `o_mem_we`, and `o_rd_valid` stays 0. Without the macro, the same access reads word 1.
- Assert `i_rst` during RMW_RD of an `SB`: no write occurs, memory is unchanged, `o_ready` = 1 on the next cycle, and all pulses are 0.
